// File: rtl/uart_pkg.sv
// uart_pkg: shared state/parity types and frame-length helper for the serial transmitter and receiver.
package uart_pkg;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} states_t;

   typedef enum logic [1:0] {
      PAR_NONE = 2'd0,
      PAR_EVEN = 2'd1,
      PAR_ODD  = 2'd2
   } parity_t;

   function automatic int frame_bits(input int d, input int parity, input int stop_bits);
      return 1 + d + ((parity != 0) ? 1 : 0) + stop_bits;
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// bit_timer: wrapping 0..BAUD_DIV-1 counter; tick marks the last cycle of every bit period.
module bit_timer #(
   parameter int BAUD_DIV = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int W = $clog2(BAUD_DIV);

   logic [W-1:0] cnt;

   assign tick = cnt == W'(BAUD_DIV - 1);

   always_ff @(posedge clk)
      if (reset || clear) cnt <= '0;
      else cnt <= tick ? '0 : cnt + 1'b1;

endmodule

// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter (start, D data bits LSB first, optional parity, 1-2 stop bits).
module uart_tx_param #(
   parameter int D         = 8,
   parameter int BAUD_DIV  = 16,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         send,
   input  logic [D-1:0] data,
   output logic         rdy,
   output logic         txd
);

   import uart_pkg::*;

   localparam int      IW    = $clog2(D + 1);
   localparam parity_t PMODE = parity_t'(PARITY[1:0]);

   states_t       state, state_n;
   logic [IW-1:0] idx, idx_n;
   logic [D-1:0]  sh, sh_n, word, word_n;
   logic          tick, accept, par_bit;

   if (D < 5 || D > 9) begin : g_bad_d
      $error("uart_tx_param: D must be in 5..9");
   end
   if (BAUD_DIV < 2) begin : g_bad_baud
      $error("uart_tx_param: BAUD_DIV must be >= 2");
   end
   if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_tx_param: PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
      $error("uart_tx_param: STOP_BITS must be 1 or 2");
   end

   // Clearing on acceptance makes the start bit a full BAUD_DIV cycles.
   bit_timer #(.BAUD_DIV(BAUD_DIV)) u_timer (
      .clk  (clk),
      .reset(reset),
      .clear(accept),
      .tick (tick)
   );

   assign accept  = (state == IDLE) && send;
   assign par_bit = (^word) ^ (PMODE == PAR_ODD);
   assign rdy     = state == IDLE;

   always_comb
      txd = state == START ? 1'b0 :
            state == DATA ? sh[0] :
            state == uart_pkg::PARITY ? par_bit : 1'b1;

   always_ff @(posedge clk)
      if (reset) begin
         state <= IDLE;
         idx   <= '0;
         sh    <= '0;
         word  <= '0;
      end else begin
         state <= state_n;
         idx   <= idx_n;
         sh    <= sh_n;
         word  <= word_n;
      end

   always_comb begin
      state_n = state;
      idx_n   = idx;
      sh_n    = sh;
      word_n  = word;
      case (state)
         IDLE:
            if (send) begin
               state_n = START;
               idx_n   = '0;
               sh_n    = data;
               word_n  = data;
            end
         START:
            if (tick) begin
               state_n = DATA;
               idx_n   = '0;
            end
         DATA:
            if (tick) begin
               sh_n = sh >> 1;
               if (idx == IW'(D - 1)) begin
                  state_n = (PMODE != PAR_NONE) ? uart_pkg::PARITY : STOP;
                  idx_n   = '0;
               end else idx_n = idx + 1'b1;
            end
         uart_pkg::PARITY:
            if (tick) begin
               state_n = STOP;
               idx_n   = '0;
            end
         STOP:
            if (tick) begin
               if (idx == IW'(STOP_BITS - 1)) begin
                  state_n = IDLE;
                  idx_n   = '0;
               end else idx_n = idx + 1'b1;
            end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: directed checks of four transmitter configurations with hand-computed frames.
module tb_uart_tx_param;

   logic       clk = 1'b0;
   logic [7:0] dat;
   logic       send  [4];
   logic       reset [4];
   logic       txd   [4];
   logic       rdy   [4];
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   uart_tx_param #(.D(8), .BAUD_DIV(4), .PARITY(0), .STOP_BITS(1)) u0 (
      .clk(clk), .reset(reset[0]), .send(send[0]), .data(dat), .rdy(rdy[0]), .txd(txd[0]));
   uart_tx_param #(.D(8), .BAUD_DIV(4), .PARITY(1), .STOP_BITS(1)) u1 (
      .clk(clk), .reset(reset[1]), .send(send[1]), .data(dat), .rdy(rdy[1]), .txd(txd[1]));
   uart_tx_param #(.D(8), .BAUD_DIV(4), .PARITY(2), .STOP_BITS(1)) u2 (
      .clk(clk), .reset(reset[2]), .send(send[2]), .data(dat), .rdy(rdy[2]), .txd(txd[2]));
   uart_tx_param #(.D(5), .BAUD_DIV(3), .PARITY(0), .STOP_BITS(2)) u3 (
      .clk(clk), .reset(reset[3]), .send(send[3]), .data(dat[4:0]), .rdy(rdy[3]), .txd(txd[3]));

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic idle_chk(input int k, input string tag);
      @(negedge clk);
      chk({tag, " txd"}, txd[k], 1'b1);
      chk({tag, " rdy"}, rdy[k], 1'b1);
   endtask

   // Assumes the frame was accepted on the preceding rising edge; bits[0] is the start bit.
   task automatic frame(input int k, input string name, input logic [12:0] bits, input int nb,
                        input int baud, input bit hold, input bit poke);
      for (int b = 0; b < nb; b++)
         for (int c = 0; c < baud; c++) begin
            @(negedge clk);
            chk($sformatf("%s bit%0d cyc%0d txd", name, b, c), txd[k], bits[b]);
            chk($sformatf("%s bit%0d cyc%0d rdy", name, b, c), rdy[k], 1'b0);
            if (!hold && b == 0 && c == 0) send[k] = 1'b0;
            if (poke && b == 3 && c == 1) begin
               send[k] = 1'b1;
               dat     = 8'h3C;
            end
            if (poke && b == 3 && c == 2) send[k] = 1'b0;
         end
      idle_chk(k, {name, " idle"});
   endtask

   initial begin
      dat = '0;
      for (int i = 0; i < 4; i++) begin
         send[i]  = 1'b0;
         reset[i] = 1'b1;
      end
      repeat (3) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("reset%0d txd", i), txd[i], 1'b1);
         chk($sformatf("reset%0d rdy", i), rdy[i], 1'b1);
      end
      chk("reset state idle", u0.state == uart_pkg::IDLE, 1'b1);
      for (int i = 0; i < 4; i++) reset[i] = 1'b0;
      idle_chk(0, "post-reset");

      dat = 8'hA5;
      send[0] = 1'b1;
      frame(0, "a5", 13'b000_1101001010, 10, 4, 1'b0, 1'b0);

      dat = 8'hA5;
      send[0] = 1'b1;
      frame(0, "a5_ignore", 13'b000_1101001010, 10, 4, 1'b0, 1'b1);
      repeat (3) idle_chk(0, "no second frame");

      dat = 8'h07;
      send[1] = 1'b1;
      frame(1, "even07", 13'b00_11000001110, 11, 4, 1'b0, 1'b0);
      dat = 8'h07;
      send[2] = 1'b1;
      frame(2, "odd07", 13'b00_10000001110, 11, 4, 1'b0, 1'b0);

      dat = 8'h1F;
      send[3] = 1'b1;
      frame(3, "d5_1f", 13'b00000_11111110, 8, 3, 1'b0, 1'b0);

      dat = 8'hA5;
      send[0] = 1'b1;
      @(negedge clk);
      send[0] = 1'b0;
      repeat (16) @(negedge clk);
      chk("pre-reset data bit3 txd", txd[0], 1'b0);
      chk("pre-reset rdy", rdy[0], 1'b0);
      reset[0] = 1'b1;
      @(negedge clk);
      chk("abort txd", txd[0], 1'b1);
      chk("abort rdy", rdy[0], 1'b1);
      chk("abort state idle", u0.state == uart_pkg::IDLE, 1'b1);
      reset[0] = 1'b0;
      idle_chk(0, "after abort");
      dat = 8'h81;
      send[0] = 1'b1;
      frame(0, "81", 13'b000_1100000010, 10, 4, 1'b0, 1'b0);

      dat = 8'h55;
      send[0] = 1'b1;
      for (int n = 0; n < 3; n++)
         frame(0, $sformatf("b2b55_%0d", n), 13'b000_1010101010, 10, 4, 1'b1, 1'b0);
      send[0] = 1'b0;
      repeat (2) idle_chk(0, "b2b end");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
